uart_endpoint: RTL and testbench
================================

# uart_endpoint

Parametrised full-duplex UART endpoint with buffered transmit and checked receive. It is the next generation of the bench-side serial model driving `mprj_io[5]` and sampling `mprj_io[6]` in the Caravel UART/DMA tests. The old fixed 8N1, single-byte start/busy handshake becomes a valid/ready TX FIFO, configurable framing, and a receive path that reports parity and framing errors. The RTL is synthesizable and reusable as a user-project UART behind a Wishbone shim.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, 5..9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥ 2.

- `wb_clk_i` input 1: the single clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `tx_valid` input 1: push request for `tx_data`.
- `tx_data` input DATA_BITS: word to transmit.
- `tx_ready` output 1: FIFO not full.
- `tx_busy` output 1: FIFO non-empty or frame in flight.
- `tx_level` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `ser_tx` output 1: serial out, idle high.
- `ser_rx` input 1: serial in; asynchronous.
- `rx_valid` output 1: one-cycle pulse when a frame has been received.
- `rx_data` output DATA_BITS: received word; held until the next `rx_valid`.
- `rx_parity_err` output 1: qualifies `rx_valid`; parity mismatch.
- `rx_frame_err` output 1: qualifies `rx_valid`; a stop bit was sampled low.

## Operation
- **TX FIFO**
  - A push occurs when `tx_valid && tx_ready`.
  - A pop occurs when the TX FSM is IDLE and the FIFO is non-empty.
  - Push and pop in the same cycle leave `tx_level` unchanged.
  - Pushes while full are ignored; the previously stored data is not corrupted.
  - Pointers wrap modulo FIFO_DEPTH; an extra-bit compare distinguishes full from empty.
- **TX FSM**
  - States: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - IDLE: `ser_tx`=1. On a pop, latch the word, compute parity and enter START.
  - START drives 0. DATA drives bit[i] for i = 0..DATA_BITS-1. PARITY drives the parity bit: odd = ~^data, even = ^data. STOP drives 1 for STOP_BITS bit times.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles; a bit counter and a baud counter control this.
  - From STOP, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames.
- **RX path**
  - `ser_rx` passes through a 2-flop synchroniser.
  - RX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - IDLE: a synchronised 1→0 edge enters START.
  - START: sample at mid-bit (CLKS_PER_BIT/2 cycles after the edge). If the sample is high the edge is treated as a glitch: return to IDLE with no output.
  - Each following bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - Data bits shift in LSB first. A parity mismatch sets the parity flag. Any stop sample equal to 0 sets the frame flag.
  - At the last stop sample, pulse `rx_valid` for one cycle with `rx_data`, `rx_parity_err` and `rx_frame_err` updated in that same cycle, then go to IDLE.
  - After a framing error, RX stays in IDLE until `ser_rx` has been high for at least one sample (break handling): a held-low line produces no further frames.
- TX and RX are fully independent and may run simultaneously.

## Timing
- **Reset values:** `ser_tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_level`=0, `rx_valid`=0, `rx_data`=0, both error flags 0; both FSMs in IDLE; FIFO emptied.
- **Reset mid-frame:** `ser_tx` returns high on the cycle after `wb_rst_i` is sampled high. The partial frame and all queued words are discarded.
- **TX latency:** a push into an empty FIFO with TX idle at edge N gives pop at N+1, with `ser_tx` low from N+2.
- `tx_busy` rises at N+1 and falls in the cycle after the final stop bit time completes.
- **Frame length:** CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- **RX latency:** `rx_valid` asserts CLKS_PER_BIT/2 + 2 cycles (synchroniser delay) into the last stop bit, measured at `ser_rx`.
- All outputs are registered.

## Test plan
- **8N1 transmit**, CLKS_PER_BIT=16: push 0x0F. Required: `ser_tx` sequence 0,1,1,1,1,0,0,0,0,1, each bit 16 cycles; `tx_busy` deasserts 160 cycles after the start bit.
- **Back-to-back fill:** push 0x0F, 0x3D, 0xA5, 0x5A, 0xFF with tx_valid held. Required: `tx_ready`=0 after 4 are queued; the 5th is accepted only after the first pop; 5 contiguous frames with no idle gap; `tx_level` tracks exactly.
- **Loopback**, `ser_tx`→`ser_rx`, 8E2: send 0x3D. Required: `rx_valid` pulses once with `rx_data`=0x3D and both error flags 0.
- **Error injection:** 8O1 frame for 0x3D with the parity bit flipped gives `rx_parity_err`=1. A stop bit forced low gives `rx_frame_err`=1. A line held low afterwards produces no further `rx_valid`.
- **Glitch:** a 3-cycle low pulse on `ser_rx` produces no `rx_valid`. A valid 0x0F frame sent 20 cycles later is received correctly.
- **Reset mid-frame:** assert `wb_rst_i` during DATA bit 3 of 0xA5. Required: `ser_tx`=1 the next cycle, `tx_level`=0, and no further frames are sent.

Source files
------------

// File: rtl/uart_endpoint.sv
// uart_endpoint: full-duplex UART, TX FIFO (valid/ready) and checked RX.
// Ports: wb_clk_i/wb_rst_i, tx_* push side, ser_tx/ser_rx line, rx_* result.
module uart_endpoint #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        ser_tx,
  input  logic                        ser_rx,
  output logic                        rx_valid,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_END = CW'(CLKS_PER_BIT - 1);
  // Edge is seen two cycles late, and START counts from one past it.
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [AW:0]          wr_n, rd_n, lvl_n;
  logic                 empty, push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  st_t                  tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bidx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_end;

  assign empty    = (wr_ptr == rd_ptr);
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_par = (PARITY == 1) ? ~(^head) : ^head;
  assign tx_end   = (tx_state == S_STOP)
                 && (tx_cnt == BAUD_END)
                 && (tx_bidx == STOP_END);
  assign pop      = !empty
                 && ((tx_state == S_IDLE) || tx_end);
  assign wr_n     = wr_ptr + LW'(push);
  assign rd_n     = rd_ptr + LW'(pop);
  assign lvl_n    = wr_n - rd_n;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      ser_tx   <= 1'b1;
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bidx  <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      tx_level <= lvl_n;
      tx_ready <= (lvl_n != LW'(FIFO_DEPTH));
      tx_busy  <= !empty || (tx_state != S_IDLE);
      unique case (tx_state)
        S_START: ser_tx <= 1'b0;
        S_DATA:  ser_tx <= tx_sh[0];
        S_PAR:   ser_tx <= tx_par;
        default: ser_tx <= 1'b1;
      endcase
      if (tx_state != S_IDLE) begin
        if (tx_cnt != BAUD_END) begin
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          tx_cnt <= '0;
          unique case (tx_state)
            S_START: begin
              tx_state <= S_DATA;
              tx_bidx  <= '0;
            end
            S_DATA: begin
              tx_sh <= tx_sh >> 1;
              if (tx_bidx == DATA_END) begin
                tx_bidx  <= '0;
                tx_state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                tx_bidx <= tx_bidx + BW'(1);
              end
            end
            S_PAR: begin
              tx_state <= S_STOP;
              tx_bidx  <= '0;
            end
            default: begin
              if (tx_bidx != STOP_END)
                tx_bidx <= tx_bidx + BW'(1);
              else
                tx_state <= S_IDLE;
            end
          endcase
        end
      end
      // Pop overrides the STOP->IDLE step: frames run back to back.
      if (pop) begin
        tx_sh    <= head;
        tx_par   <= head_par;
        tx_cnt   <= '0;
        tx_bidx  <= '0;
        tx_state <= S_START;
      end
    end
  end

  logic                 rx_s1, rx_s2, rx_s3;
  st_t                  rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bidx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr, rx_ferr, rx_brk;
  logic                 rx_par_exp, rx_ferr_n;

  assign rx_par_exp = (PARITY == 1) ? ~(^rx_sh) : ^rx_sh;
  assign rx_ferr_n  = rx_ferr | ~rx_s2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_s3         <= 1'b1;
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bidx       <= '0;
      rx_sh         <= '0;
      rx_perr       <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_brk        <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_s1    <= ser_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      unique case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          // After a framing error wait for the line to go high again.
          if (rx_brk)
            rx_brk <= ~rx_s2;
          else if (rx_s3 && !rx_s2)
            rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt != HALF_END) begin
            rx_cnt <= rx_cnt + CW'(1);
          end else begin
            rx_cnt   <= '0;
            rx_bidx  <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end
        end
        default: begin
          if (rx_cnt != BAUD_END) begin
            rx_cnt <= rx_cnt + CW'(1);
          end else begin
            rx_cnt <= '0;
            unique case (rx_state)
              S_DATA: begin
                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bidx == DATA_END) begin
                  rx_bidx  <= '0;
                  rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                  rx_bidx <= rx_bidx + BW'(1);
                end
              end
              S_PAR: begin
                rx_perr  <= (rx_s2 != rx_par_exp);
                rx_bidx  <= '0;
                rx_state <= S_STOP;
              end
              default: begin
                if (rx_bidx != STOP_END) begin
                  rx_ferr <= rx_ferr_n;
                  rx_bidx <= rx_bidx + BW'(1);
                end else begin
                  rx_valid      <= 1'b1;
                  rx_data       <= rx_sh;
                  rx_parity_err <= rx_perr;
                  rx_frame_err  <= rx_ferr_n;
                  rx_brk        <= rx_ferr_n;
                  rx_state      <= S_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_endpoint.sv
// tb_uart_endpoint: scoreboard bench for uart_endpoint (8N1, 8E2, 8O1).
// Stimulus pushes expectations; line and rx monitors pop and compare.
module tb_uart_endpoint;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass = 0;
  int total = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  logic       rst_a = 1'b1, rst_bc = 1'b1;
  logic       txv_a = 0, txv_b = 0, txv_c = 0;
  logic [7:0] txd_a = 0, txd_b = 0, txd_c = 0;
  logic       rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;
  logic       stx_a, stx_b, stx_c;
  logic       srx_a = 1'b1, srx_c = 1'b1;
  logic       rxv_a, rxv_b, rxv_c;
  logic [7:0] rxd_a, rxd_b, rxd_c;
  logic       rpe_a, rpe_b, rpe_c, rfe_a, rfe_b, rfe_c;

  uart_endpoint #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a),
    .tx_valid(txv_a), .tx_data(txd_a), .tx_ready(rdy_a),
    .tx_busy(busy_a), .tx_level(lvl_a), .ser_tx(stx_a),
    .ser_rx(srx_a), .rx_valid(rxv_a), .rx_data(rxd_a),
    .rx_parity_err(rpe_a), .rx_frame_err(rfe_a));

  uart_endpoint #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst_bc),
    .tx_valid(txv_b), .tx_data(txd_b), .tx_ready(rdy_b),
    .tx_busy(busy_b), .tx_level(lvl_b), .ser_tx(stx_b),
    .ser_rx(stx_b), .rx_valid(rxv_b), .rx_data(rxd_b),
    .rx_parity_err(rpe_b), .rx_frame_err(rfe_b));

  uart_endpoint #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst_bc),
    .tx_valid(txv_c), .tx_data(txd_c), .tx_ready(rdy_c),
    .tx_busy(busy_c), .tx_level(lvl_c), .ser_tx(stx_c),
    .ser_rx(srx_c), .rx_valid(rxv_c), .rx_data(rxd_c),
    .rx_parity_err(rpe_c), .rx_frame_err(rfe_c));

  logic [7:0] txq_a[$];
  logic [9:0] rxq_a[$], rxq_b[$], rxq_c[$];
  int         starts[$];
  int         rxn_a = 0, rxn_b = 0, rxn_c = 0;
  int         last_b = 0;

  // Serial decoder on u_a's line; frames cut by reset are dropped.
  initial begin : txmon
    logic [9:0] bits;
    logic       hit;
    int         t0;
    forever begin
      @(negedge clk);
      if (stx_a === 1'b0) begin
        t0  = cyc;
        hit = rst_a;
        for (int k = 0; k < 10; k++) begin
          repeat (k == 0 ? 7 : 16) begin
            @(negedge clk);
            hit |= rst_a;
          end
          bits[k] = stx_a;
        end
        if (!hit) begin
          starts.push_back(t0);
          if (txq_a.size() == 0) begin
            total++;
            $display("FAIL tx_unexpected: got %0h", bits[8:1]);
          end else begin
            chk("tx_word", 32'(bits[8:1]), 32'(txq_a.pop_front()));
          end
          chk("tx_stop", 32'(bits[9]), 32'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rxv_a) begin
      rxn_a++;
      if (rxq_a.size() == 0) begin
        total++;
        $display("FAIL rxa_unexpected: got %0h", rxd_a);
      end else
        chk("rxa_frame", 32'({rxd_a, rpe_a, rfe_a}),
            32'(rxq_a.pop_front()));
    end
    if (rxv_b) begin
      rxn_b++;
      last_b = cyc;
      if (rxq_b.size() == 0) begin
        total++;
        $display("FAIL rxb_unexpected: got %0h", rxd_b);
      end else
        chk("rxb_frame", 32'({rxd_b, rpe_b, rfe_b}),
            32'(rxq_b.pop_front()));
    end
    if (rxv_c) begin
      rxn_c++;
      if (rxq_c.size() == 0) begin
        total++;
        $display("FAIL rxc_unexpected: got %0h", rxd_c);
      end else
        chk("rxc_frame", 32'({rxd_c, rpe_c, rfe_c}),
            32'(rxq_c.pop_front()));
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input logic [7:0] d, output int at);
    int   w;
    logic ok;
    txv_a = 1'b1;
    txd_a = d;
    w = 0;
    do begin
      @(negedge clk);
      ok = rdy_a;
      @(posedge clk);
      #1;
      w++;
    end while (!ok && w < 2000);
    if (!ok) begin
      total++;
      $display("FAIL push_timeout: got ready 0 want 1");
    end
    at = cyc;
  endtask

  task automatic send_raw(input bit to_c, input logic [10:0] b,
                          input int n);
    for (int k = 0; k < n; k++) begin
      if (to_c) srx_c = b[k];
      else srx_a = b[k];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, a0, a, nb, lows;
    logic [9:0] pat;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_a_tx", 32'({stx_a, rdy_a, busy_a, lvl_a}), 32'b110000);
    chk("rst_a_rx", 32'({rxv_a, rxd_a, rpe_a, rfe_a}), 32'd0);
    chk("rst_b", 32'({stx_b, rdy_b, busy_b, lvl_b}), 32'b110000);
    chk("rst_c_rx", 32'({rxv_c, rxd_c, rpe_c, rfe_c}), 32'd0);
    rst_a = 1'b0;
    rst_bc = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 single frame, bit-exact timing
    txq_a.push_back(8'h0F);
    push_a(8'h0F, n);
    txv_a = 1'b0;
    chk("t1_busy_n", 32'(busy_a), 32'd0);
    chk("t1_lvl_n", 32'(lvl_a), 32'd1);
    to_cyc(n + 1);
    chk("t1_busy_n1", 32'(busy_a), 32'd1);
    chk("t1_lvl_n1", 32'(lvl_a), 32'd0);
    chk("t1_idle_n1", 32'(stx_a), 32'd1);
    to_cyc(n + 2);
    chk("t1_start_n2", 32'(stx_a), 32'd0);
    pat = 10'b1000011110;
    for (int k = 0; k < 10; k++) begin
      to_cyc(n + 10 + 16 * k);
      chk($sformatf("t1_bit%0d", k), 32'(stx_a), 32'(pat[k]));
    end
    to_cyc(n + 161);
    chk("t1_busy_161", 32'(busy_a), 32'd1);
    to_cyc(n + 162);
    chk("t1_busy_162", 32'(busy_a), 32'd0);

    // back-to-back fill, FIFO full, no gaps
    repeat (10) @(posedge clk);
    #1;
    starts.delete();
    txq_a.push_back(8'h0F);
    txq_a.push_back(8'h3D);
    txq_a.push_back(8'hA5);
    txq_a.push_back(8'h5A);
    txq_a.push_back(8'hFF);
    txq_a.push_back(8'h77);
    push_a(8'h0F, a0);
    chk("t2_lvl0", 32'(lvl_a), 32'd1);
    push_a(8'h3D, a);
    chk("t2_lvl1", 32'(lvl_a), 32'd1);
    push_a(8'hA5, a);
    chk("t2_lvl2", 32'(lvl_a), 32'd2);
    push_a(8'h5A, a);
    chk("t2_lvl3", 32'(lvl_a), 32'd3);
    push_a(8'hFF, a);
    chk("t2_lvl4", 32'(lvl_a), 32'd4);
    chk("t2_full", 32'(rdy_a), 32'd0);
    push_a(8'h77, a);
    txv_a = 1'b0;
    chk("t2_accept6", 32'(a - a0), 32'd162);
    chk("t2_lvl_after", 32'(lvl_a), 32'd4);
    for (int i = 0; i < 3000 && busy_a; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_drain", 32'(busy_a), 32'd0);
    chk("t2_nframes", 32'(starts.size()), 32'd6);
    for (int i = 1; i < starts.size(); i++)
      chk($sformatf("t2_gap%0d", i),
          32'(starts[i] - starts[i-1]), 32'd160);

    // glitch then valid frame on u_a
    srx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srx_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rxq_a.push_back({8'h0F, 2'b00});
    send_raw(1'b0, {3'b111, 8'h0F}, 1);
    send_raw(1'b0, {2'b11, 8'h0F, 1'b0}, 10);
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_count", 32'(rxn_a), 32'd1);

    // 8E2 loopback
    rxq_b.push_back({8'h3D, 2'b00});
    txv_b = 1'b1;
    txd_b = 8'h3D;
    @(posedge clk);
    #1;
    nb = cyc;
    txv_b = 1'b0;
    for (int i = 0; i < 500 && rxn_b == 0; i++) @(posedge clk);
    #1;
    chk("lb_latency", 32'(last_b - nb), 32'd188);
    repeat (300) @(posedge clk);
    #1;
    chk("lb_once", 32'(rxn_b), 32'd1);

    // 8O1 parity error, framing error, held low, recovery
    rxq_c.push_back({8'h3D, 2'b10});
    send_raw(1'b1, {1'b1, 1'b1, 8'h3D, 1'b0}, 11);
    repeat (20) @(posedge clk);
    #1;
    rxq_c.push_back({8'h3D, 2'b01});
    send_raw(1'b1, {1'b0, 1'b0, 8'h3D, 1'b0}, 11);
    repeat (400) @(posedge clk);
    #1;
    chk("brk_count", 32'(rxn_c), 32'd2);
    chk("brk_hold", 32'(rxd_c), 32'h3D);
    srx_c = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rxq_c.push_back({8'h0F, 2'b00});
    send_raw(1'b1, {1'b1, 1'b1, 8'h0F, 1'b0}, 11);
    repeat (40) @(posedge clk);
    #1;
    chk("recover_count", 32'(rxn_c), 32'd3);

    // reset during data bit 3 of 0xA5 with words queued
    push_a(8'hA5, n);
    push_a(8'h11, a);
    push_a(8'h22, a);
    txv_a = 1'b0;
    to_cyc(n + 69);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_line", 32'(stx_a), 32'd1);
    chk("mid_rst_lvl", 32'(lvl_a), 32'd0);
    chk("mid_rst_state", 32'({rdy_a, busy_a}), 32'b10);
    rst_a = 1'b0;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (!stx_a) lows++;
    end
    chk("mid_rst_quiet", 32'(lows), 32'd0);

    chk("txq_empty", 32'(txq_a.size()), 32'd0);
    chk("rxq_a_empty", 32'(rxq_a.size()), 32'd0);
    chk("rxq_b_empty", 32'(rxq_b.size()), 32'd0);
    chk("rxq_c_empty", 32'(rxq_c.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
